// File: rtl/ga_int_pkg.sv
// ga_int_pkg: shared types and constants for the GA40010 interrupt generator.
package ga_int_pkg;

    // VSYNC resynchronisation state
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } vs_state_t;

    localparam int INT_PERIOD_DEF = 52;
    localparam int VS_DELAY_DEF   = 2;
    localparam int RESYNC_THRESH  = 32;

endpackage

// File: rtl/edge_det.sv
// edge_det: one-bit registered rise/fall detector. The previous-sample
// register resets to 0, so a level already low at reset release gives no fall.
module edge_det (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_prev_reg;

    // Remember the last sample and register the edge strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            d_prev_reg <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            d_prev_reg <= d;
            rise       <= ~d_prev_reg & d;
            fall       <= d_prev_reg & ~d;
        end
    end

endmodule

// File: rtl/ga_int_gen.sv
// ga_int_gen: GA40010 interrupt timing generator. Counts HSYNC falling edges,
// issues a set strobe every INT_PERIOD lines and a reset strobe on CPU
// acknowledge or register clear. The VSYNC resync FSM is compiled in only when
// GA_INT_VSYNC_RESYNC_EN is defined; otherwise the counter runs free.
module ga_int_gen
    import ga_int_pkg::*;
#(
    parameter int INT_PERIOD = INT_PERIOD_DEF,
    parameter int VS_DELAY   = VS_DELAY_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       int_ack,
    input  logic       reg_clr,
    output logic       int_set,
    output logic       int_rst,
    output logic [5:0] count
);

    localparam logic [6:0] PERIOD7 = 7'(INT_PERIOD);
    localparam logic [5:0] THRESH6 = 6'(RESYNC_THRESH);

    logic       hs_fall;
    logic       hs_rise_unused;
    logic       ack_reg;
    logic       clr_reg;
    logic [5:0] count_reg;
    logic [5:0] count_next;
    logic [5:0] masked;
    logic [6:0] inc;
    logic       set_next;
    logic       rst_next;
    logic       resync_hit;
    logic       int_set_reg;
    logic       int_rst_reg;

    edge_det u_hs_edge (
        .clock (clock),
        .reset (reset),
        .d     (hsync),
        .rise  (hs_rise_unused),
        .fall  (hs_fall)
    );

    // Register the CPU pulses so they line up with the registered line edge
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_reg <= 1'b0;
            clr_reg <= 1'b0;
        end else begin
            ack_reg <= int_ack;
            clr_reg <= reg_clr;
        end
    end

`ifdef GA_INT_VSYNC_RESYNC_EN
    localparam logic [5:0] VS_DELAY6 = 6'(VS_DELAY);

    logic       vs_rise;
    logic       vs_fall_unused;
    vs_state_t  state_reg;
    logic [5:0] vs_cnt_reg;

    edge_det u_vs_edge (
        .clock (clock),
        .reset (reset),
        .d     (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall_unused)
    );

    // The line edge that brings vs_cnt to zero performs the resync
    assign resync_hit = hs_fall && (state_reg == WAIT) && (vs_cnt_reg <= 6'd1);

    // VSYNC FSM: wait VS_DELAY lines after a VSYNC rise, then resync the counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            vs_cnt_reg <= 6'd0;
        end else if (clr_reg) begin
            state_reg  <= IDLE;
            vs_cnt_reg <= 6'd0;
        end else if (vs_rise) begin
            // A new VSYNC (re)starts the delay even while already waiting
            state_reg  <= WAIT;
            vs_cnt_reg <= VS_DELAY6;
        end else if (state_reg == WAIT && hs_fall) begin
            if (vs_cnt_reg <= 6'd1) begin
                state_reg  <= IDLE;
                vs_cnt_reg <= 6'd0;
            end else begin
                vs_cnt_reg <= vs_cnt_reg - 6'd1;
            end
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign resync_hit   = 1'b0;
`endif

    // Next counter value and strobes: clear beats everything, then the bit-5
    // mask from an acknowledge, then the line increment or resync on top of it
    always_comb begin
        masked     = count_reg;
        inc        = 7'd0;
        count_next = count_reg;
        set_next   = 1'b0;
        rst_next   = 1'b0;
        if (clr_reg) begin
            count_next = 6'd0;
            rst_next   = 1'b1;
        end else begin
            if (ack_reg) begin
                masked   = {1'b0, count_reg[4:0]};
                rst_next = 1'b1;
            end
            count_next = masked;
            if (hs_fall) begin
                if (resync_hit) begin
                    set_next   = (masked >= THRESH6);
                    count_next = 6'd0;
                end else begin
                    inc = {1'b0, masked} + 7'd1;
                    if (inc == PERIOD7) begin
                        count_next = 6'd0;
                        set_next   = 1'b1;
                    end else begin
                        count_next = inc[5:0];
                    end
                end
            end
        end
    end

    // Register counter and one-cycle strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg   <= 6'd0;
            int_set_reg <= 1'b0;
            int_rst_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            int_set_reg <= set_next;
            int_rst_reg <= rst_next;
        end
    end

    assign count   = count_reg;
    assign int_set = int_set_reg;
    assign int_rst = int_rst_reg;

endmodule
